result_commit_fifo: RTL and testbench
=====================================

// Module: result_commit_fifo
// PURPOSE
//  Downstream stage of the operation unit. Captures each (result_addr, result) write it
//  produces into an in-order commit FIFO and presents the entries to a consumer over
//  valid/ready. The consumer is the result memory writer or the DPI golden-model checker.
//  Also tracks total commits, sticky overflow and an out-of-order-address error.
// PARAMETERS
//  MEM_DEPTH   8   result memory depth; sets address width AW = $clog2(MEM_DEPTH)
//  MEM_WIDTH   32  result data width
//  FIFO_DEPTH  4   commit entries; must be a power of 2, >= 2
//  CNT_W       16  width of the total-commit counter
// PORTS
//  clk_i           in   1                      clock, rising edge
//  rst_ni          in   1                      asynchronous reset, active low
//  valid_i         in   1                      upstream write strobe, one entry per cycle when high
//  addr_i          in   AW                     result address from operation unit
//  data_i          in   MEM_WIDTH              result data from operation unit
//  commit_ready_i  in   1                      consumer accepts head entry
//  commit_valid_o  out  1                      head entry available
//  commit_addr_o   out  AW                     head entry address
//  commit_data_o   out  MEM_WIDTH              head entry data
//  count_o         out  $clog2(FIFO_DEPTH+1)   occupied entries
//  full_o          out  1                      count_o == FIFO_DEPTH
//  empty_o         out  1                      count_o == 0
//  overflow_o      out  1                      sticky: a push was dropped
//  addr_err_o      out  1                      sticky: accepted addr_i != expected sequential addr
//  commits_o       out  CNT_W                  total entries popped since reset
// BEHAVIOUR
//  - Reset (asynchronous assert, synchronous-to-clock deassert handled externally):
//    pointers, count_o, commits_o, expected addr = 0; overflow_o = addr_err_o = 0;
//    empty_o = 1; full_o = 0; commit_valid_o = 0. Storage array is not reset.
//  - Reset mid-operation discards all entries immediately. Outputs take reset values
//    asynchronously.
//  - push = valid_i && (!full_o || pop). pop = commit_valid_o && commit_ready_i.
//  - First-word-fall-through: commit_* shows the head whenever !empty_o.
//    commit_addr_o/commit_data_o = 0 when empty.
//  - Push-to-visible latency is 1 cycle. There is no same-cycle bypass.
//    A push into an empty FIFO raises commit_valid_o on the next edge.
//  - Simultaneous push and pop: count unchanged. When full, the pop frees the slot
//    and the push is accepted.
//  - valid_i while full with no pop: entry dropped, overflow_o set, count unchanged.
//    The expected address does not advance.
//  - Consumer must hold commit_ready_i meaningful only with commit_valid_o. The head is
//    stable while commit_valid_o && !commit_ready_i.
//  - Pointers are AW_F = $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//    full/empty are derived from count_o.
//  - On each accepted push, compare addr_i with expected address exp_q. A mismatch sets
//    addr_err_o. Either way exp_q <= addr_i + 1 mod MEM_DEPTH (resynchronises).
//  - commits_o increments by 1 per pop and wraps at 2**CNT_W.
//  - No combinational path from valid_i/data_i to commit_* outputs.
//    commit_ready_i affects only next state.
// TESTING
//  1 Reset, then push addr 0..3 data 10,20,30,40 with ready=0
//    -> full_o=1, count_o=4, head addr 0 data 10.
//  2 From full, valid_i addr 4 data 50, ready=0
//    -> dropped, overflow_o=1 sticky, count_o stays 4.
//  3 From full, valid_i and ready both 1 for 1 cycle
//    -> pop 10, push accepted, count_o=4, commits_o=1.
//  4 Push addr 0..7 then 0 again with ready=1 throughout
//    -> drain order 0..7,0, addr_err_o=0, commits_o=9, pointer wrap clean.
//  5 Push addr 0,1,3 -> addr_err_o=1 after addr 3; then push 4 -> no further effect, stays 1.
//  6 Assert rst_ni=0 with 3 entries queued mid-cycle
//    -> outputs clear before next edge; after release, empty_o=1 and commits_o=0.

Source files
------------

// File: rtl/result_commit_fifo.sv
// In-order commit FIFO between the operation unit and the result consumer.
// First-word-fall-through head. Tracks commit count, sticky overflow and address-sequence errors.
module result_commit_fifo #(
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 valid_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]         addr_i,
  input  logic [MEM_WIDTH-1:0]                 data_i,
  input  logic                                 commit_ready_i,
  output logic                                 commit_valid_o,
  output logic [$clog2(MEM_DEPTH)-1:0]         commit_addr_o,
  output logic [MEM_WIDTH-1:0]                 commit_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic                                 overflow_o,
  output logic                                 addr_err_o,
  output logic [CNT_W-1:0]                     commits_o
);

  localparam int unsigned AW   = $clog2(MEM_DEPTH);
  localparam int unsigned AW_F = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  logic [AW-1:0]        addr_mem [FIFO_DEPTH];
  logic [MEM_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [AW_F-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    exp_q;
  logic             overflow_q, addr_err_q;
  logic [CNT_W-1:0] commits_q;
  logic             push, pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && commit_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push  = valid_i && (!full || pop);

  // Storage deliberately has no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= addr_i;
      data_mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exp_q      <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
      commits_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW_F'(1);
        if (addr_i != exp_q) addr_err_q <= 1'b1;
        exp_q <= (addr_i == AW'(MEM_DEPTH - 1)) ? '0 : addr_i + AW'(1);
      end
      if (valid_i && !push) overflow_q <= 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW_F'(1);
        commits_q <= commits_q + CNT_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_comb begin
    commit_valid_o = !empty;
    commit_addr_o  = '0;
    commit_data_o  = '0;
    if (!empty) begin
      commit_addr_o = addr_mem[rd_ptr_q];
      commit_data_o = data_mem[rd_ptr_q];
    end
  end

  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;
  assign addr_err_o = addr_err_q;
  assign commits_o  = commits_q;

endmodule

// File: tb/tb_result_commit_fifo.sv
// Randomised and directed checks of result_commit_fifo against a queue-based reference model.
module tb_result_commit_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic        ready_i = 1'b0;
  logic        commit_valid;
  logic [2:0]  commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  count;
  logic        full, empty, overflow, addr_err;
  logic [15:0] commits;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [2:0] a; logic [31:0] d; } entry_t;
  entry_t      mq[$];
  logic [2:0]  m_exp;
  logic        m_ovf, m_err;
  logic [15:0] m_commits;
  logic [2:0]  got[$];

  result_commit_fifo #(.MEM_DEPTH(8), .MEM_WIDTH(32), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i),
    .commit_ready_i(ready_i), .commit_valid_o(commit_valid), .commit_addr_o(commit_addr),
    .commit_data_o(commit_data), .count_o(count), .full_o(full), .empty_o(empty),
    .overflow_o(overflow), .addr_err_o(addr_err), .commits_o(commits)
  );

  initial forever #5 clk = ~clk;

  task automatic model_clear();
    mq.delete(); got.delete();
    m_exp = '0; m_ovf = 1'b0; m_err = 1'b0; m_commits = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its own queue.
  task automatic step(input logic v, input logic [2:0] a, input logic [31:0] d, input logic r);
    bit m_full, m_pop, m_push;
    valid_i = v; addr_i = a; data_i = d; ready_i = r;
    if (commit_valid && r) got.push_back(commit_addr);
    m_full = (mq.size() == 4);
    m_pop  = (mq.size() > 0) && r;
    m_push = v && (!m_full || m_pop);
    @(posedge clk);
    if (m_pop) begin
      void'(mq.pop_front());
      m_commits++;
    end
    if (m_push) begin
      if (a != m_exp) m_err = 1'b1;
      m_exp = a + 3'd1;
      mq.push_back('{a: a, d: d});
    end
    if (v && !m_push) m_ovf = 1'b1;
    #1;
    valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL reset_flags empty=%b full=%b count=%0d want 1 0 0", empty, full, count); end
    checks++; if (commit_valid !== 1'b0 || commit_addr !== 3'd0 || commit_data !== 32'd0) begin
      failures++; $display("FAIL reset_head valid=%b addr=%0d data=%0d want 0 0 0", commit_valid, commit_addr, commit_data); end
    checks++; if (overflow !== 1'b0 || addr_err !== 1'b0 || commits !== 16'd0) begin
      failures++; $display("FAIL reset_sticky ovf=%b err=%b commits=%0d want 0 0 0", overflow, addr_err, commits); end
    do_reset();
  endtask

  task automatic test_fill_full();
    valid_i = 1'b1; addr_i = 3'd0; data_i = 32'd10; #1;
    checks++; if (commit_valid !== 1'b0) begin
      failures++; $display("FAIL no_bypass commit_valid=%b want 0", commit_valid); end
    step(1'b1, 3'd0, 32'd10, 1'b0);
    checks++; if (commit_valid !== 1'b1 || commit_addr !== 3'd0 || commit_data !== 32'd10) begin
      failures++; $display("FAIL push_latency valid=%b addr=%0d data=%0d want 1 0 10", commit_valid, commit_addr, commit_data); end
    for (int i = 1; i < 4; i++) step(1'b1, 3'(i), 32'((i + 1) * 10), 1'b0);
    checks++; if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
      failures++; $display("FAIL fill_full full=%b count=%0d empty=%b want 1 4 0", full, count, empty); end
    checks++; if (commit_addr !== 3'd0 || commit_data !== 32'd10) begin
      failures++; $display("FAIL fill_head addr=%0d data=%0d want 0 10", commit_addr, commit_data); end
  endtask

  task automatic test_overflow();
    step(1'b1, 3'd4, 32'd50, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== 3'd4 || commit_data !== 32'd10) begin
      failures++; $display("FAIL overflow_drop ovf=%b count=%0d head=%0d want 1 4 10", overflow, count, commit_data); end
    step(1'b0, 3'd0, 32'd0, 1'b0);
    checks++; if (overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_sticky ovf=%b want 1", overflow); end
  endtask

  task automatic test_full_pushpop();
    step(1'b1, 3'd4, 32'd50, 1'b1);
    checks++; if (count !== 3'd4 || commits !== 16'd1 || commit_data !== 32'd20 || commit_addr !== 3'd1) begin
      failures++; $display("FAIL full_pushpop count=%0d commits=%0d head=%0d/%0d want 4 1 1/20", count, commits, commit_addr, commit_data); end
    checks++; if (addr_err !== 1'b0) begin
      failures++; $display("FAIL full_pushpop_err err=%b want 0 (drop must not advance exp)", addr_err); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (commit_valid !== 1'b1 || commit_addr !== mq[0].a || commit_data !== mq[0].d) begin
        failures++; $display("FAIL drain_order[%0d] addr=%0d data=%0d want %0d %0d", i, commit_addr, commit_data, mq[0].a, mq[0].d); end
      step(1'b0, 3'd0, 32'd0, 1'b1);
    end
    checks++; if (empty !== 1'b1 || commits !== 16'd5 || commit_addr !== 3'd0) begin
      failures++; $display("FAIL drain_empty empty=%b commits=%0d addr=%0d want 1 5 0", empty, commits, commit_addr); end
  endtask

  task automatic test_wrap_stream();
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 3'(i % 8), $urandom, 1'b1);
    step(1'b0, 3'd0, 32'd0, 1'b1);
    checks++; if (got.size() != 9) begin
      failures++; $display("FAIL wrap_count popped=%0d want 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++; if (got[i] !== 3'(i % 8)) begin
        failures++; $display("FAIL wrap_order[%0d] addr=%0d want %0d", i, got[i], i % 8); end
    end
    checks++; if (addr_err !== 1'b0 || commits !== 16'd9 || empty !== 1'b1) begin
      failures++; $display("FAIL wrap_end err=%b commits=%0d empty=%b want 0 9 1", addr_err, commits, empty); end
  endtask

  task automatic test_addr_err();
    do_reset();
    step(1'b1, 3'd0, 32'd1, 1'b1);
    step(1'b1, 3'd1, 32'd2, 1'b1);
    checks++; if (addr_err !== 1'b0) begin
      failures++; $display("FAIL addr_seq_ok err=%b want 0", addr_err); end
    step(1'b1, 3'd3, 32'd3, 1'b1);
    checks++; if (addr_err !== 1'b1) begin
      failures++; $display("FAIL addr_gap err=%b want 1", addr_err); end
    step(1'b1, 3'd4, 32'd4, 1'b1);
    step(1'b0, 3'd0, 32'd0, 1'b1);
    checks++; if (addr_err !== 1'b1 || m_exp !== 3'd5) begin
      failures++; $display("FAIL addr_err_sticky err=%b want 1", addr_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 32'(i + 100), 1'b0);
    step(1'b0, 3'd0, 32'd0, 1'b1);
    checks++; if (count !== 3'd3 || commits !== 16'd1) begin
      failures++; $display("FAIL pre_reset count=%0d commits=%0d want 3 1", count, commits); end
    #3; rst_n = 1'b0; #1;
    checks++; if (empty !== 1'b1 || count !== 3'd0 || commit_valid !== 1'b0 || commits !== 16'd0 || commit_addr !== 3'd0) begin
      failures++; $display("FAIL async_reset empty=%b count=%0d valid=%b commits=%0d addr=%0d want 1 0 0 0 0",
                           empty, count, commit_valid, commits, commit_addr); end
    @(negedge clk); rst_n = 1'b1; model_clear();
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1 || commits !== 16'd0 || full !== 1'b0) begin
      failures++; $display("FAIL post_reset empty=%b commits=%0d full=%b want 1 0 0", empty, commits, full); end
  endtask

  task automatic test_random();
    logic [2:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 3'($urandom) : m_exp;
      step($urandom_range(0, 9) < 7, a, $urandom, $urandom_range(0, 1) == 1);
      checks++;
      if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 4) ||
          commit_valid !== (mq.size() != 0) || overflow !== m_ovf || addr_err !== m_err ||
          commits !== m_commits ||
          commit_addr !== (mq.size() != 0 ? mq[0].a : 3'd0) ||
          commit_data !== (mq.size() != 0 ? mq[0].d : 32'd0)) begin
        failures++;
        $display("FAIL random[%0d] cnt=%0d ovf=%b err=%b commits=%0d head=%0d/%0h want cnt=%0d ovf=%b err=%b commits=%0d",
                 n, count, overflow, addr_err, commits, commit_addr, commit_data,
                 mq.size(), m_ovf, m_err, m_commits);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill_full();
    test_overflow();
    test_full_pushpop();
    test_wrap_stream();
    test_addr_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
